// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target (responder) block.
package spi_target_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int         DATA_W_DEF    = 8;
    localparam int         CNT_W         = $clog2(DATA_W_DEF + 1);
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

    // Bit counter must hold 0..DATA_W inclusive.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_target_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// Oversampled SPI target with tx holding register and rx byte output.
// Optional SPI_TARGET_MODE_SEL_EN adds spi_cpol/spi_cpha mode selection (default: mode 0).
module spi_target
    import spi_target_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEF,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_ss,
`ifdef SPI_TARGET_MODE_SEL_EN
    input  logic              spi_cpol,
    input  logic              spi_cpha,
`endif
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int            CW       = cnt_width(DATA_W);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_full_q, hold_full_d;
    logic              oe_q, oe_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              load;

    logic sck_lvl_unused, sck_rise, sck_fall;
    logic ss_lvl_unused, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic sample_edge, shift_edge, cpha;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(wb_clk_i), .rst_n(wb_rst_n), .d(spi_sck),
        .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(wb_clk_i), .rst_n(wb_rst_n), .d(spi_ss),
        .q(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(wb_clk_i), .rst_n(wb_rst_n), .d(spi_mosi),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

`ifdef SPI_TARGET_MODE_SEL_EN
    logic cpol_q, cpol_d, cpha_q, cpha_d;
    logic lead_edge, trail_edge;

    // Mode pins are only followed while deselected so a frame never changes mode.
    always_comb begin
        cpol_d      = (state_q == IDLE) ? spi_cpol : cpol_q;
        cpha_d      = (state_q == IDLE) ? spi_cpha : cpha_q;
        lead_edge   = cpol_q ? sck_fall : sck_rise;
        trail_edge  = cpol_q ? sck_rise : sck_fall;
        sample_edge = cpha_q ? trail_edge : lead_edge;
        shift_edge  = cpha_q ? lead_edge : trail_edge;
        cpha        = cpha_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else begin
            cpol_q <= cpol_d;
            cpha_q <= cpha_d;
        end
    end
`else
    always_comb begin
        sample_edge = sck_rise;
        shift_edge  = sck_fall;
        cpha        = 1'b0;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        oe_d        = oe_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                    cnt_d   = '0;
                    oe_d    = ~cpha;
                end
            end
            ACTIVE: begin
                // ss-rise is checked first so it beats a coincident sck edge.
                if (ss_rise) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    cnt_d   = '0;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                    end
                end else if (shift_edge) begin
                    if (cnt_q == FULL_CNT) begin
                        load  = 1'b1;
                        cnt_d = '0;
                    end else if (cpha && cnt_q == '0) begin
                        oe_d = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reload sees the register as it was this cycle; a same-cycle user write stays held.
        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_data_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end

        if (tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            oe_q        <= 1'b0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            oe_q        <= oe_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_miso    = oe_q & tx_shift_q[DATA_W-1];
    assign spi_miso_oe = oe_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: table of single frames plus hand sequences.
module tb_spi_target;

    localparam int H = 8;

    typedef struct {
        logic       hold;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_und;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       spi_sck, spi_mosi, spi_ss, spi_miso, spi_miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;
`ifdef SPI_TARGET_MODE_SEL_EN
    logic       spi_cpol, spi_cpha;
`endif

    int         total = 0;
    int         bad = 0;
    int         rx_cnt = 0;
    int         und_cnt = 0;
    logic [7:0] rx_hist[$];
    logic [7:0] tx_q[$];
    logic       mid_oe, mid_busy;

    spi_target dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_ss      (spi_ss),
`ifdef SPI_TARGET_MODE_SEL_EN
        .spi_cpol    (spi_cpol),
        .spi_cpha    (spi_cpha),
`endif
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            rx_hist.push_back(rx_data);
        end
        if (tx_underrun === 1'b1) und_cnt++;
    end

    // Feeds queued tx bytes through the valid/ready handshake.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            tx_valid = 1'b0;
        end else if (tx_valid) begin
            check("tx_ready_drop", 32'(tx_ready), 0);
            tx_valid = 1'b0;
        end else if (tx_ready === 1'b1 && tx_q.size() > 0) begin
            tx_data  = tx_q.pop_front();
            tx_valid = 1'b1;
        end
    end

    task automatic wait_loaded();
        int n;
        n = 0;
        while (tx_ready !== 1'b0 && n < 50) begin
            wait_cyc(1);
            n++;
        end
        check("tx_load_timeout", 32'(n < 50), 1);
    endtask

    // Mode-0 controller: mosi set after sck falls, miso captured just before sck rises.
    task automatic spi_run(input logic [31:0] mo, input int nbits, input bit tie_end,
                           output logic [31:0] mi);
        mi = '0;
        spi_ss = 1'b0;
        wait_cyc(H);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[nbits-1-i];
            wait_cyc(H);
            mi = {mi[30:0], spi_miso};
            if (i == 0) begin
                mid_oe   = spi_miso_oe;
                mid_busy = busy;
            end
            spi_sck = 1'b1;
            wait_cyc(H);
            spi_sck = 1'b0;
            if (tie_end && i == nbits - 1) spi_ss = 1'b1;
        end
        if (!tie_end) begin
            wait_cyc(H);
            spi_ss = 1'b1;
        end
        wait_cyc(H);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[5];
        logic [31:0] mi;
        int          rx0, u0, n;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A, 1};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0};
        vecs[4] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80, 0};

`ifdef SPI_TARGET_MODE_SEL_EN
        spi_cpol = 1'b0;
        spi_cpha = 1'b0;
`endif
        rst_n    = 1'b0;
        spi_ss   = 1'b0;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            spi_sck = ~spi_sck;
        end
        check("rst_miso", 32'(spi_miso), 0);
        check("rst_oe", 32'(spi_miso_oe), 0);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_underrun", 32'(tx_underrun), 0);
        check("rst_busy", 32'(busy), 0);

        spi_ss  = 1'b1;
        spi_sck = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(6);
        check("post_rst_busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            rx0 = rx_cnt;
            u0  = und_cnt;
            if (vecs[i].hold) begin
                tx_q.push_back(vecs[i].tx);
                wait_loaded();
            end
            spi_run({24'h0, vecs[i].mosi}, 8, 1'b1, mi);
            check($sformatf("v%0d_miso", i), mi, {24'h0, vecs[i].exp_miso});
            check($sformatf("v%0d_rx_data", i), 32'(rx_data), {24'h0, vecs[i].exp_rx});
            check($sformatf("v%0d_rx_pulses", i), rx_cnt - rx0, 1);
            check($sformatf("v%0d_underrun", i), und_cnt - u0, vecs[i].exp_und);
            check($sformatf("v%0d_mid_oe", i), 32'(mid_oe), 1);
            check($sformatf("v%0d_mid_busy", i), 32'(mid_busy), 1);
            check($sformatf("v%0d_tx_ready", i), 32'(tx_ready), 1);
            check($sformatf("v%0d_end_busy", i), 32'(busy), 0);
            check($sformatf("v%0d_end_oe", i), 32'(spi_miso_oe), 0);
        end

        // Back-to-back: three bytes in one select, refilled as each is consumed;
        // the reload after the final fall finds the register empty.
        rx0 = rx_cnt;
        u0  = und_cnt;
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        wait_loaded();
        spi_run(32'h0001_0203, 24, 1'b0, mi);
        n = rx_hist.size();
        check("b2b_miso", mi, 32'h0011_2233);
        check("b2b_rx_pulses", rx_cnt - rx0, 3);
        check("b2b_rx0", 32'(rx_hist[n-3]), 32'h01);
        check("b2b_rx1", 32'(rx_hist[n-2]), 32'h02);
        check("b2b_rx2", 32'(rx_hist[n-1]), 32'h03);
        check("b2b_underrun", und_cnt - u0, 1);
        check("b2b_tx_ready", 32'(tx_ready), 1);

        // Abort after five bits, then a clean frame.
        rx0 = rx_cnt;
        u0  = und_cnt;
        tx_q.push_back(8'h5A);
        wait_loaded();
        spi_run(32'h0000_001F, 5, 1'b0, mi);
        check("abort_miso_bits", mi, 32'h0B);
        check("abort_no_rx", rx_cnt - rx0, 0);
        check("abort_underrun", und_cnt - u0, 0);
        check("abort_oe", 32'(spi_miso_oe), 0);
        check("abort_miso", 32'(spi_miso), 0);
        check("abort_busy", 32'(busy), 0);
        tx_q.push_back(8'h96);
        wait_loaded();
        spi_run(32'h0000_0069, 8, 1'b1, mi);
        check("after_abort_miso", mi, 32'h96);
        check("after_abort_rx", 32'(rx_data), 32'h69);
        check("after_abort_pulses", rx_cnt - rx0, 1);

        // Reset in the middle of a frame.
        spi_ss = 1'b0;
        wait_cyc(H);
        spi_sck = 1'b1;
        wait_cyc(H);
        spi_sck = 1'b0;
        wait_cyc(4);
        check("midrst_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        wait_cyc(2);
        check("midrst_oe", 32'(spi_miso_oe), 0);
        check("midrst_miso", 32'(spi_miso), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_tx_ready", 32'(tx_ready), 1);
        spi_ss = 1'b1;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(6);
        check("midrst_idle", 32'(busy), 0);

`ifdef SPI_TARGET_MODE_SEL_EN
        // Mode 3: sck idles high, target drives on falls, samples on rises.
        spi_sck  = 1'b1;
        spi_cpol = 1'b1;
        spi_cpha = 1'b1;
        wait_cyc(10);
        rx0 = rx_cnt;
        tx_q.push_back(8'h5A);
        wait_loaded();
        mi = '0;
        spi_ss = 1'b0;
        wait_cyc(H);
        check("m3_oe_before_lead", 32'(spi_miso_oe), 0);
        for (int i = 0; i < 8; i++) begin
            spi_sck  = 1'b0;
            spi_mosi = 8'hC3 >> (7 - i);
            wait_cyc(H);
            mi = {mi[30:0], spi_miso};
            spi_sck = 1'b1;
            wait_cyc(H);
        end
        spi_ss = 1'b1;
        wait_cyc(H);
        check("m3_miso", mi, 32'h5A);
        check("m3_rx", 32'(rx_data), 32'hC3);
        check("m3_pulses", rx_cnt - rx0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder (target) for the opposite end of the SPI controller link: consumes sck/mosi/ss from an external controller and drives miso.
- Oversamples all SPI pins in the Wishbone clock domain; nothing is clocked on sck.
- Exposes a byte-stream parallel interface: a tx holding register with valid/ready, and an rx output with a one-cycle valid pulse.
- Sits beside the other peripherals inside user_project, on spare GPIO pads.

Parameters:
- DATA_W, 8, bits per SPI frame; MSB first.
- IDLE_BYTE, 8'hFF, byte shifted out when no tx data is held at frame start.
- SYNC_STAGES, 2, synchronizer flops on sck/mosi/ss (minimum 2).

Ports:
- wb_clk_i  input  1  system clock, sole clock domain.
- wb_rst_n  input  1  synchronous active-low reset.
- spi_sck  input  1  SPI clock from controller, asynchronous.
- spi_mosi  input  1  controller-to-target data.
- spi_ss  input  1  chip select, active low.
- spi_miso  output  1  target-to-controller data.
- spi_miso_oe  output  1  1 = drive miso pad; 0 while deselected.
- tx_data  input  DATA_W  next byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty.
- rx_data  output  DATA_W  last complete received byte.
- rx_valid  output  1  one-cycle pulse, rx_data updated.
- tx_underrun  output  1  one-cycle pulse, IDLE_BYTE sent.
- busy  output  1  selected, i.e. state ACTIVE.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_n is synchronous and active-low.
- Reset values: spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0. Synchronizers reset to idle: sck=0, ss=1.
- Mode 0 (CPOL=0, CPHA=0) unless the optional feature below is compiled in.
- Edges: rise/fall/ss-fall/ss-rise are detected on the synchronized samples (sampled-previous comparison).
- Timing requirement: sck high and low phases each ≥ 4 wb_clk_i cycles. Narrower pulses are undefined.
- Pin-to-internal latency is SYNC_STAGES+1 cycles.
- Tx holding register:
  - A transfer occurs when tx_valid && tx_ready.
  - tx_ready drops the next cycle.
  - tx_ready rises the cycle after the holding register is loaded into the shift register.
- States IDLE, ACTIVE.
  - IDLE -> ACTIVE on ss-fall.
    - Load the tx shifter from the holding register if it is full; otherwise load IDLE_BYTE and pulse tx_underrun.
    - bitcnt=0; drive miso=shifter MSB; miso_oe=1.
  - ACTIVE, sck rise: shift sampled mosi into the rx shifter LSB; bitcnt++.
  - ACTIVE, sck fall:
    - If bitcnt != DATA_W: shift the tx shifter left and drive the next bit.
    - If bitcnt == DATA_W: reload the tx shifter (same rule as frame start) and set bitcnt=0.
  - Frame complete: on the rise with bitcnt reaching DATA_W, rx_data = the full byte the next cycle and rx_valid pulses 1 cycle.
  - ACTIVE -> IDLE on ss-rise at any point.
    - Partial rx bits are discarded: no rx_valid.
    - The partial tx byte is lost; the holding register is untouched if not yet consumed.
    - miso_oe=0, miso=0.
- No rx backpressure: a new byte overwrites rx_data.
- Simultaneous events:
  - Holding-register load by the user in the same cycle as the frame-start reload: the reload sees the register empty, so IDLE_BYTE is sent and the new data stays held.
  - ss-rise in the same cycle as an sck edge: ss-rise wins.
- Reset asserted mid-frame: immediate return to reset values. The frame is abandoned; the controller sees miso undriven.

Optional Feature:
- Macro: SPI_TARGET_MODE_SEL_EN.
- Defined:
  - Adds input ports spi_cpol and spi_cpha, each 1 bit, quasi-static and sampled only in IDLE.
  - Idle sck level = cpol. Sample edge = leading edge if cpha=0, trailing edge if cpha=1.
  - With cpha=1, miso is first driven on the first leading edge, not on ss-fall.
- Undefined: ports are absent; behaviour is fixed mode 0.

Decomposition:
- Package spi_target_pkg:
  - state enum IDLE/ACTIVE.
  - DATA_W-derived bit-counter width constant, $clog2(DATA_W+1).
  - Default IDLE_BYTE constant.
- Sub-module spi_target_sync: SYNC_STAGES-deep synchronizer plus rise/fall edge detector. Instantiated for sck and ss; mosi uses sync only.

Test Plan:
- Reset: hold wb_rst_n=0 for 3 cycles with ss low and sck toggling -> all outputs at reset values, tx_ready=1.
- Basic frame: hold tx 0xA5, controller sends 0x3C with an 8-clock sck phase -> miso shows 10100101; rx_data=0x3C with a single rx_valid pulse; tx_ready returns to 1.
- Back-to-back: 3 bytes 0x01/0x02/0x03 under one ss-low, tx refilled after each tx_ready -> rx_valid pulses 3 times; miso carries 0x11/0x22/0x33.
- Underrun: no tx_valid at ss-fall -> miso shows 0xFF; tx_underrun pulses once at frame start.
- Abort: ss rises after 5 sck rises -> no rx_valid, miso_oe=0, busy=0; the next full frame receives correctly.
- With SPI_TARGET_MODE_SEL_EN, mode 3 (cpol=1, cpha=1): controller sends 0xC3, tx 0x5A -> rx_data=0xC3 and miso shows 0x5A.
